// File: rtl/lfsr_prng_pkg.sv
// Shared constants and types for the LFSR pseudo-random source.
// Defaults describe the HRSS 16-bit polynomial x^16+x^14+x^13+x^11+1.
package prng_pkg;

  localparam logic [15:0] HRSS_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'h0001;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } prng_state_e;

endpackage

// File: rtl/lfsr_prng_if.sv
// Valid/ready word stream carrying packed random words to the consumer.
interface lfsr_prng_if #(
  parameter int OUT_W = 8
) ();

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/lfsr_prng_step.sv
// One Fibonacci LFSR shift: feedback is the parity of the tapped bits.
module lfsr_step #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out,
  output logic             fb
);

  assign fb        = ^(state_in & TAPS);
  assign state_out = {state_in[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR stepping STEPS bits per clock, packing them into OUT_W-bit
// words behind a one-word valid/ready output buffer, with guarded reseeding.
module lfsr_prng
  import prng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(HRSS_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
  parameter int               OUT_W = 8,
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  lfsr_prng_if.master      out_if,
  output logic             lockup,
  output logic             stalled
);

  localparam int WORDS = OUT_W / STEPS;
  localparam int CNT_W = $clog2(WORDS + 1);

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_prng: SEED must be non-zero");
  end
  if ((OUT_W % STEPS) != 0) begin : g_bad_steps
    $error("lfsr_prng: OUT_W must be divisible by STEPS");
  end
  if ((WIDTH < 3) || (WIDTH > 64)) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be in 3..64");
  end

  prng_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [OUT_W-1:0] coll_q, coll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;

  logic [STEPS:0][WIDTH-1:0] chain_w;
  logic [STEPS-1:0]          fb_w;
  logic [OUT_W-1:0]          coll_step;

  // Combinational chain of STEPS shifts; fb_w[0] is the oldest bit produced.
  assign chain_w[0] = state_q;
  for (genvar k = 0; k < STEPS; k++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .state_in  (chain_w[k]),
      .state_out (chain_w[k+1]),
      .fb        (fb_w[k])
    );
  end

  always_comb begin
    coll_step = coll_q;
    for (int k = 0; k < STEPS; k++) begin
      coll_step = (coll_step << 1) | OUT_W'(fb_w[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= FILL;
      state_q  <= SEED;
      coll_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      coll_q   <= coll_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    coll_d   = coll_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    lockup_d = 1'b0;

    if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end

    // Reseeding discards the partial word but leaves the output buffer alone.
    if (seed_load) begin
      if (seed_in == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = seed_in;
      end
      coll_d = '0;
      cnt_d  = '0;
      fsm_d  = FILL;
    end else begin
      unique case (fsm_q)
        FILL: begin
          if (en) begin
            state_d = chain_w[STEPS];
            coll_d  = coll_step;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WORDS - 1)) begin
              if (!valid_q || out_if.out_ready) begin
                data_d  = coll_step;
                valid_d = 1'b1;
                coll_d  = '0;
                cnt_d   = '0;
              end else begin
                fsm_d = FULL;
              end
            end
          end
        end
        FULL: begin
          // Buffer move is not gated by en so a drained buffer never idles in FULL.
          if (out_if.out_ready) begin
            data_d  = coll_q;
            valid_d = 1'b1;
            coll_d  = '0;
            cnt_d   = '0;
            fsm_d   = FILL;
          end
        end
      endcase
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign lockup           = lockup_q;
  assign stalled          = (fsm_q == FULL);

endmodule
